// File: rtl/bsg_id_alloc_sched_pkg.sv
// Shared types and width helpers for the ID allocator/scheduler.
package bsg_id_alloc_sched_pkg;

  // Flush sequencer states.
  typedef enum logic [1:0] {
    eRun   = 2'd0,
    eDrain = 2'd1,
    eDone  = 2'd2
  } bsg_id_alloc_state_e;

  // Bits needed to index n items; never less than 1.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the value n itself (0..n).
  function automatic int width_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bsg_id_alloc_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
module bsg_id_alloc_rr_arb
  import bsg_id_alloc_sched_pkg::*;
#(
  parameter int reqs_p = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [reqs_p-1:0] v_i,
  input  logic              en_i,
  output logic [reqs_p-1:0] grant_o
);

  localparam int ptr_width_lp = safe_clog2(reqs_p);

  logic [ptr_width_lp-1:0] ptr_q, ptr_d;
  logic                    found;
  int                      idx;

  // Search requesters starting at the pointer; the winner's successor becomes the next pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < reqs_p; i++) begin
      idx = (int'(ptr_q) + i) % reqs_p;
      if (en_i && !found && v_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
        ptr_d        = ptr_width_lp'((idx + 1) % reqs_p);
      end
    end
  end

  // Pointer register; with a single requester it stays at 0.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bsg_id_alloc_sched.sv
// ID allocator: round-robin grants of the lowest free ID, single free port,
// and a flush sequencer that waits for all IDs to return.
module bsg_id_alloc_sched
  import bsg_id_alloc_sched_pkg::*;
#(
  parameter  int els_p        = 8,
  parameter  int reqs_p       = 4,
  localparam int id_width_lp  = safe_clog2(els_p),
  localparam int cnt_width_lp = width_of(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [reqs_p-1:0]       req_v_i,
  output logic [reqs_p-1:0]       req_yumi_o,
  output logic [id_width_lp-1:0]  alloc_id_o,
  input  logic                    free_v_i,
  input  logic [id_width_lp-1:0]  free_id_i,
  input  logic                    flush_v_i,
  output logic                    flush_done_o,
  output logic [els_p-1:0]        scoreboard_r_o,
  output logic [cnt_width_lp-1:0] count_r_o,
  output logic                    full_o,
  output logic                    empty_o
);

  bsg_id_alloc_state_e     state_q;
  logic                    flush_done_q;
  logic [els_p-1:0]        sb_q, sb_d;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic                    grant_en, grant_v, legal_free;

  assign full_o         = (count_q == cnt_width_lp'(els_p));
  assign empty_o        = (count_q == '0);
  assign scoreboard_r_o = sb_q;
  assign count_r_o      = count_q;
  assign flush_done_o   = flush_done_q;

  // Grants are held off while reset is asserted so req_yumi_o is 0 even before any edge.
  assign grant_en = reset_n_i && (state_q == eRun) && !full_o;
  assign grant_v  = |req_yumi_o;

  bsg_id_alloc_rr_arb #(.reqs_p(reqs_p)) u_arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (req_v_i),
    .en_i      (grant_en),
    .grant_o   (req_yumi_o)
  );

  // Lowest clear scoreboard bit, from registered state only (no free-to-grant path).
  always_comb begin
    alloc_id_o = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (!sb_q[i]) alloc_id_o = id_width_lp'(i);
    end
  end

  // Next scoreboard and occupancy: set the granted bit, clear a legally freed bit.
  always_comb begin
    legal_free = free_v_i && sb_q[free_id_i];
    sb_d       = sb_q;
    count_d    = count_q;
    if (grant_v)    sb_d[alloc_id_o] = 1'b1;
    if (legal_free) sb_d[free_id_i]  = 1'b0;
    if (grant_v && !legal_free)      count_d = count_q + cnt_width_lp'(1);
    else if (!grant_v && legal_free) count_d = count_q - cnt_width_lp'(1);
  end

  // Scoreboard and count registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sb_q    <= '0;
      count_q <= '0;
    end else begin
      sb_q    <= sb_d;
      count_q <= count_d;
    end
  end

  // Flush sequencer: RUN -> DRAIN on flush, DRAIN -> DONE once empty, DONE pulses done for one cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= eRun;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        eRun:   if (flush_v_i) state_q <= eDrain;
        eDrain: if (count_q == '0) begin
                  state_q      <= eDone;
                  flush_done_q <= 1'b1;
                end
        eDone:  state_q <= eRun;
        default: state_q <= eRun;
      endcase
    end
  end

  // Freeing an ID that is not allocated is a requester bug; the scoreboard ignores it.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && free_v_i)
      assert (sb_q[free_id_i]) else $warning("illegal free of unallocated id %0d", free_id_i);
  end

endmodule
